// File: rtl/sync_count_pkg.sv
// Shared constants and load-clamp helper for the synchronous up counter family.
// The clamp function is also the reference the bench uses for the load path.
package sync_count_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 16;

  // Out-of-range load values saturate to the terminal count rather than wrap.
  function automatic logic [15:0] clamp_load(input logic [15:0] val, input int modulus);
    int lim;
    lim = modulus - 1;
    return (int'(val) > lim) ? 16'(lim) : val;
  endfunction

endpackage

// File: rtl/sync_up_count_if.sv
// Control/status bundle for one counter stage; master drives en/load/clr_ovf,
// slave (the counter) returns the count and terminal-count/carry/wrap/overflow flags.
interface sync_up_count_if #(
  parameter int WIDTH = sync_count_pkg::DEF_WIDTH
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             carry_out;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, load, load_val, clr_ovf,
    input  q, tc, carry_out, wrap, ovf
  );

  modport slave (
    input  en, load, load_val, clr_ovf,
    output q, tc, carry_out, wrap, ovf
  );

endinterface

// File: rtl/tff_cell.sv
// One counter bit: toggle flop with async active-high reset and synchronous clear.
// Latency one clock; no backpressure, clear takes precedence over toggle.
module tff_cell (
  input  logic clock,
  input  logic reset,
  input  logic t,
  input  logic clr,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = clr ? 1'b0 : (q_q ^ t);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sync_up_count.sv
// Synchronous modulo-MODULUS up counter with clamped parallel load, cascade carry, wrap pulse, sticky ovf.
// Latency: q/wrap/ovf one clock after sampling; tc/carry_out combinational. No backpressure: en gates counting.
module sync_up_count
  import sync_count_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             clock,
  input  logic             reset,
  sync_up_count_if.slave   bus
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] lower_ones;
  logic [WIDTH-1:0] toggle;
  logic             run;
  logic             at_tc;
  logic             wrap_cond;
  logic             wrap_d;
  logic             wrap_q;
  logic             ovf_d;
  logic             ovf_q;

  always_comb begin
    at_tc        = (q == TC_VAL);
    wrap_cond    = ~bus.load & bus.en & at_tc;
    load_clamped = WIDTH'(clamp_load(16'(bus.load_val), MODULUS));

    lower_ones = '0;
    run        = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      lower_ones[i] = run;
      run           = run & q[i];
    end

    // A load is expressed as toggling exactly the bits that differ from the target.
    toggle = bus.load ? (q ^ load_clamped) : ({WIDTH{bus.en}} & lower_ones);

    wrap_d = wrap_cond;
    ovf_d  = wrap_cond | (ovf_q & ~bus.clr_ovf);
  end

  // The wrap condition doubles as the synchronous clear, covering non-power-of-two moduli.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_cell (
      .clock (clock),
      .reset (reset),
      .t     (toggle[i]),
      .clr   (wrap_cond),
      .q     (q[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.q         = q;
  assign bus.tc        = at_tc;
  assign bus.carry_out = wrap_cond;
  assign bus.wrap      = wrap_q;
  assign bus.ovf       = ovf_q;

endmodule
